// File: rtl/nibble_serial_subtractor.sv
// Bit-serial-by-nibble subtractor: diff = a - b - bin, one 4-bit nibble per clock, LSB first.
// Optional signed-overflow output ovf is enabled by defining NIBBLE_SUB_OVERFLOW_EN.
module nibble_serial_subtractor #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 bin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] diff,
`ifdef NIBBLE_SUB_OVERFLOW_EN
    output logic                 ovf,
`endif
    output logic                 bout
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_reg, state_next;
    logic [W-1:0]     a_reg, b_inv_reg, diff_reg;
    logic             carry_reg, bout_reg;
    logic [IDX_W-1:0] idx_reg;

    logic [3:0] a_nibs [NIBBLES];
    logic [3:0] b_nibs [NIBBLES];
    logic [3:0] a_nib, b_nib, prop;
    logic [4:0] ripple;
    logic       carry_out;

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nibs[gi] = a_reg[4*gi +: 4];
            assign b_nibs[gi] = b_inv_reg[4*gi +: 4];
        end
    endgenerate

    assign a_nib  = a_nibs[idx_reg];
    assign b_nib  = b_nibs[idx_reg];
    assign prop   = a_nib ^ b_nib;
    assign ripple = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_reg};
    // Carry-skip: a fully propagating nibble passes its carry-in straight through.
    assign carry_out = (&prop) ? carry_reg : ripple[4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = CALC;
            end
            CALC: begin
                if (idx_reg == LAST_IDX) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef NIBBLE_SUB_OVERFLOW_EN
    logic ovf_reg;
    assign ovf = ovf_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_inv_reg <= '0;
            diff_reg  <= '0;
            carry_reg <= 1'b0;
            bout_reg  <= 1'b0;
            idx_reg   <= '0;
`ifdef NIBBLE_SUB_OVERFLOW_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_inv_reg <= ~b;
                        carry_reg <= ~bin;
                        idx_reg   <= '0;
                    end
                end
                CALC: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx_reg == IDX_W'(i)) diff_reg[4*i +: 4] <= ripple[3:0];
                    end
                    carry_reg <= carry_out;
                    idx_reg   <= idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        idx_reg  <= '0;
                        bout_reg <= ~carry_out;
`ifdef NIBBLE_SUB_OVERFLOW_EN
                        // Last nibble's sum bit 3 is the result sign bit.
                        ovf_reg  <= (a_reg[W-1] ^ ~b_inv_reg[W-1]) & (ripple[3] ^ a_reg[W-1]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff = diff_reg;
    assign bout = bout_reg;
endmodule

// File: doc/nibble_serial_subtractor.md
NIBBLE_SERIAL_SUBTRACTOR -- requirements
Module: nibble_serial_subtractor

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4: operand width in 4-bit nibbles, legal range 1..16; W = 4*NIBBLES.
REQ-002 It SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 It SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 It SHALL have port in_valid  input  1  operand request valid.
REQ-005 It SHALL have port in_ready  output  1  block can accept operands.
REQ-006 It SHALL have port a  input  W  minuend.
REQ-007 It SHALL have port b  input  W  subtrahend.
REQ-008 It SHALL have port bin  input  1  borrow-in.
REQ-009 It SHALL have port out_valid  output  1  result valid.
REQ-010 It SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 It SHALL have port diff  output  W  a - b - bin, modulo 2^W.
REQ-012 It SHALL have port bout  output  1  borrow-out, 1 when a < b + bin (unsigned).

Function
REQ-013 The FSM SHALL have the states IDLE, CALC and DONE; in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-014 Accept SHALL occur on an edge with in_valid & in_ready: a, b and ~bin are latched as the carry, b is stored inverted, nibble index = 0, and IDLE -> CALC.
REQ-015 Operand inputs SHALL be ignored outside IDLE.
REQ-016 In CALC, each edge SHALL add one nibble, LSB first: a_nib + ~b_nib + carry; the sum nibble is written to diff[4i+3:4i], and the carry register is updated.
REQ-017 The per-nibble carry-out SHALL use carry-skip: when all four propagate bits (a^~b) are 1, carry-out = carry-in; otherwise it is the ripple carry.
REQ-018 After NIBBLES CALC edges, the FSM SHALL go CALC -> DONE; out_valid therefore rises exactly NIBBLES edges after the accept edge.
REQ-019 In DONE, bout SHALL equal ~final carry.
REQ-020 In DONE, diff and bout SHALL be held stable until out_valid & out_ready, then DONE -> IDLE.
REQ-021 While out_ready = 0, the FSM SHALL stay in DONE indefinitely, with in_ready = 0 (backpressure).
REQ-022 Throughput SHALL be one operation per NIBBLES+2 cycles at best (accept, NIBBLES compute, drain).
REQ-023 diff and bout SHALL be undefined-free at all times and SHALL keep their last value outside DONE; consumers sample them only with out_valid.
REQ-024 When NIBBLES = 1, the block SHALL do a single CALC cycle and behave otherwise identically.

Reset
REQ-025 rst = 1 SHALL force, without a clock: state IDLE, in_ready = 1 once released, out_valid = 0, diff = 0, bout = 0, carry = 0, index = 0, ovf = 0.
REQ-026 Reset asserted in CALC or DONE SHALL abort the operation; the partial result is discarded and never presented.

Configuration
REQ-027 The macro NIBBLE_SUB_OVERFLOW_EN, when defined, SHALL add output port ovf (1 bit), valid in DONE.
REQ-028 With NIBBLE_SUB_OVERFLOW_EN defined, ovf SHALL be 1 iff a[W-1] != b[W-1] and diff[W-1] != a[W-1] (signed two's-complement overflow).
REQ-029 When NIBBLE_SUB_OVERFLOW_EN is undefined, port ovf and its logic SHALL be absent; all other behaviour is unchanged.

Verification (NIBBLES = 4)
REQ-030 Bench SHALL drive a=0x1234, b=0x0234, bin=0, out_ready=1 -> out_valid 4 edges after accept, diff=0x1000, bout=0, in_ready back to 1 the edge after.
REQ-031 Bench SHALL drive a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1 (all-propagate skip path in nibbles 1-3).
REQ-032 Bench SHALL drive a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1; the same operands with bin=0 -> diff=0x0000, bout=0.
REQ-033 Bench SHALL drive a=0x8000, b=0x0001 with the macro defined -> diff=0x7FFF, bout=0, ovf=1; a=0x7FFF, b=0x0001 -> ovf=0.
REQ-034 Bench SHALL hold out_ready=0 for 3 cycles in DONE -> diff/bout/out_valid stable, in_ready=0, and in_valid pulses are ignored; raising out_ready -> IDLE the next edge.
REQ-035 Bench SHALL assert rst 2 edges after accept -> out_valid=0, diff=0 immediately; after release, no stale result appears and a new accept computes correctly.
